usart_tx_fifo_engine: RTL and testbench
=======================================

// Module: usart_tx_fifo_engine
// PURPOSE
//  Parametrised USART transmitter: FIFO-buffered, runtime 5..DATA_MAX-bit characters, none/even/odd parity, 1/2 stop bits.
//  Owns the full frame FSM and the serial output flop. One bit period per i_txclk pulse from the baud generator.
//  Sits between the register file (UDR write path) and the TxD pin.
// PARAMETERS
//  DATA_MAX    9   widest character in bits (5..9); sets the width of i_tx_data
//  FIFO_DEPTH  4   TX FIFO depth in words (power of two, >=2)
// PORTS
//  i_fosk       in   1                        system clock; the single clock
//  i_rst        in   1                        synchronous, active-high reset
//  i_txclk      in   1                        bit-period enable, one-cycle pulse
//  i_txen       in   1                        transmitter enable
//  i_we_udr     in   1                        write strobe for i_tx_data into the FIFO
//  i_tx_data    in   DATA_MAX                 character, LSB transmitted first
//  i_char_len   in   4                        character length 5..DATA_MAX; out-of-range values clamp to that range
//  i_upm        in   2                        parity mode: 0x none, 10 even, 11 odd
//  i_usbs       in   1                        0 = one stop bit, 1 = two stop bits
//  i_txc_clr    in   1                        clears o_txc
//  i_break      in   1                        break request; present only with USART_TX_BREAK_EN
//  o_TxD        out  1                        serial output (registered)
//  o_udre       out  1                        FIFO not full (count != FIFO_DEPTH)
//  o_txc        out  1                        sticky transmit-complete flag
//  o_busy       out  1                        FSM not IDLE
//  o_level      out  $clog2(FIFO_DEPTH)+1     FIFO occupancy
// BEHAVIOUR
//  Reset values: o_TxD=1, o_udre=1, o_txc=0, o_busy=0, o_level=0. FIFO flushed, FSM IDLE.
//  - A reset mid-frame aborts the frame; o_TxD returns to 1 on the reset edge.
//  FIFO writes:
//  - A write is accepted iff o_udre=1 in that cycle. A write while full is silently dropped.
//  - count_next = count + wr_accepted - pop. A simultaneous write and pop is legal.
//  FSM timing:
//  - States: IDLE, START, DATA, PARITY, STOP1, STOP2. The state names the bit currently on o_TxD.
//  - The FSM advances only on cycles with i_txclk=1. o_TxD changes on that same edge.
//  IDLE:
//  - If i_txen=1 and the FIFO is non-empty: pop the head and latch it in the shift register.
//  - Latch char_len, upm and usbs for the whole frame; later port changes do not affect it.
//  - Drive o_TxD=0 and go to START.
//  START:
//  - Drive bit0 and go to DATA. Bit counter = 1; parity accumulator initialised to upm[0].
//  DATA:
//  - While counter < char_len: drive the next bit, XOR it into the parity accumulator, increment the counter.
//  - After the last data bit: go to PARITY (o_TxD = accumulator) if upm[1]=1, else go to STOP1 (o_TxD=1).
//  - Even parity: the data bits plus the parity bit contain an even number of ones. Odd parity: an odd number.
//  PARITY:
//  - Go to STOP1, o_TxD=1.
//  STOP1:
//  - If usbs=1: go to STOP2, o_TxD stays 1.
//  - Otherwise the frame ends; see frame end below.
//  STOP2:
//  - The frame ends; see frame end below.
//  Frame end:
//  - If i_txen=1 and the FIFO is non-empty: pop and go to START with o_TxD=0. There is no idle gap between back-to-back frames.
//  - Otherwise: go to IDLE and set o_txc.
//  o_txc:
//  - The set and i_txc_clr in the same cycle: set wins.
//  - An accepted write also clears o_txc.
//  i_txen:
//  - Dropping i_txen mid-frame lets the current frame finish, then the FSM stays IDLE. FIFO contents are kept.
// CONFIGURATION
//  Macro USART_TX_BREAK_EN:
//  - Defined: i_break exists. When i_break=1 and the FSM is IDLE, o_TxD is driven 0 on the next i_txclk and held until i_break=0.
//    Frames do not start while break is active. A frame in progress completes before break takes effect.
//  - Undefined: no i_break port and no break logic.
// STRUCTURE
//  Shared package usart_pkg: FSM state enum, UPM encodings (UPM_NONE/EVEN/ODD), CHAR_LEN_MIN=5 constant.
//  Sub-module usart_tx_fifo: synchronous FIFO with push/pop/count, parametrised by width and depth.
//  The parent holds the FSM, shift register, parity accumulator, TxD flop and flags.
// TESTING
//  T1 8N1 ('h55), char_len=8, upm=00, usbs=0:
//     expect o_TxD per txclk 0,1,0,1,0,1,0,1,0,1, then idle; o_txc=1 after the stop bit.
//  T2 7E2 ('h41), char_len=7, upm=10, usbs=1:
//     expect data 1000001, parity 0, stop bits 1,1 (11 bits total).
//  T3 9O1 ('h1FF), char_len=9, upm=11:
//     expect 9 ones, then parity 0 (nine ones is already odd), then stop.
//  T4 FIFO: write 5 words with FIFO_DEPTH=4 while txen=0:
//     expect o_udre=0 after the 4th write, the 5th write dropped, o_level=4.
//     Then txen=1: four back-to-back frames with no idle bit between them.
//  T5 Reset mid-DATA: expect o_TxD=1, o_level=0, o_busy=0 on the next edge.
//     A new write then transmits cleanly.
//  T6 (USART_TX_BREAK_EN) i_break=1 during a frame:
//     expect the frame to complete, o_TxD=0 until break is released, and queued data to be sent afterwards.

Source files
------------

// File: rtl/usart_pkg.sv
// Shared definitions for the USART transmitter: frame FSM state codes,
// parity-mode encodings, the minimum character length and a helper that
// clamps a requested character length into the supported range.
package usart_pkg;

    // Shortest character the transmitter will send
    localparam logic [3:0] CHAR_LEN_MIN = 4'd5;

    // Parity mode encodings; 2'b01 also means "no parity"
    localparam logic [1:0] UPM_NONE = 2'b00;
    localparam logic [1:0] UPM_EVEN = 2'b10;
    localparam logic [1:0] UPM_ODD  = 2'b11;

    // Frame FSM states; each state names the bit currently on the TxD line
    typedef logic [2:0] tx_state_t;
    localparam tx_state_t ST_IDLE   = 3'd0;
    localparam tx_state_t ST_START  = 3'd1;
    localparam tx_state_t ST_DATA   = 3'd2;
    localparam tx_state_t ST_PARITY = 3'd3;
    localparam tx_state_t ST_STOP1  = 3'd4;
    localparam tx_state_t ST_STOP2  = 3'd5;

    // Clamp a requested character length into CHAR_LEN_MIN..len_max
    function automatic logic [3:0] clamp_char_len(input logic [3:0] len,
                                                  input logic [3:0] len_max);
        if (len < CHAR_LEN_MIN) begin
            return CHAR_LEN_MIN;
        end else if (len > len_max) begin
            return len_max;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/usart_tx_fifo.sv
// Synchronous TX FIFO for the USART transmitter. Pushes while full and pops
// while empty are ignored; a simultaneous push and pop is legal. The head
// word is presented combinationally so the frame FSM can latch it on pop.
module usart_tx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    import usart_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Qualify push/pop against the current occupancy
    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        head    = mem[rd_ptr];
    end

    // Storage array; no reset needed since count guards every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/usart_tx_fifo_engine.sv
// USART transmitter: FIFO-buffered frame engine producing start, 5..DATA_MAX
// data bits (LSB first), optional even/odd parity and one or two stop bits.
// One bit period per i_txclk pulse. Frame settings are latched when a word is
// popped so register writes mid-frame never corrupt the frame on the wire.
// Optional feature macro: USART_TX_BREAK_EN adds the i_break port, which
// holds TxD low while the FSM is idle.
module usart_tx_fifo_engine #(
    parameter int DATA_MAX   = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_fosk,
    input  logic                          i_rst,
    input  logic                          i_txclk,
    input  logic                          i_txen,
    input  logic                          i_we_udr,
    input  logic [DATA_MAX-1:0]           i_tx_data,
    input  logic [3:0]                    i_char_len,
    input  logic [1:0]                    i_upm,
    input  logic                          i_usbs,
    input  logic                          i_txc_clr,
`ifdef USART_TX_BREAK_EN
    input  logic                          i_break,
`endif
    output logic                          o_TxD,
    output logic                          o_udre,
    output logic                          o_txc,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);
    import usart_pkg::*;

    localparam logic [3:0] LEN_MAX = 4'(DATA_MAX);

    tx_state_t             state;
    logic [DATA_MAX-1:0]   shift_reg;
    logic [3:0]            bit_cnt;
    logic [3:0]            len_l;
    logic [1:0]            upm_l;
    logic                  usbs_l;
    logic                  parity_acc;
    logic                  txd_q;
    logic                  txc_q;

    logic [DATA_MAX-1:0]   fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  wr_accepted;
    logic                  can_start;
    logic                  frame_end;
    logic                  pop;
    logic                  txc_set;
    logic                  parity_en;

    usart_tx_fifo #(
        .WIDTH (DATA_MAX),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_fosk),
        .rst       (i_rst),
        .push      (i_we_udr),
        .push_data (i_tx_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (o_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Decide when a new frame may start and when the current one is ending
    always_comb begin
        wr_accepted = i_we_udr && !fifo_full;
`ifdef USART_TX_BREAK_EN
        can_start   = i_txen && !fifo_empty && !i_break;
`else
        can_start   = i_txen && !fifo_empty;
`endif
        frame_end   = ((state == ST_STOP1) && !usbs_l) || (state == ST_STOP2);
        pop         = i_txclk && can_start && ((state == ST_IDLE) || frame_end);
        txc_set     = i_txclk && frame_end && !can_start;
        parity_en   = (upm_l == UPM_EVEN) || (upm_l == UPM_ODD);
    end

    // Frame FSM, shift register and registered TxD; advances only on i_txclk
    always_ff @(posedge i_fosk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            len_l      <= CHAR_LEN_MIN;
            upm_l      <= UPM_NONE;
            usbs_l     <= 1'b0;
            parity_acc <= 1'b0;
            txd_q      <= 1'b1;
        end else if (i_txclk) begin
            if (pop) begin
                shift_reg <= fifo_head;
                len_l     <= clamp_char_len(i_char_len, LEN_MAX);
                upm_l     <= i_upm;
                usbs_l    <= i_usbs;
                txd_q     <= 1'b0;
                state     <= ST_START;
            end else begin
                case (state)
                    ST_IDLE: begin
`ifdef USART_TX_BREAK_EN
                        txd_q <= !i_break;
`else
                        txd_q <= 1'b1;
`endif
                    end
                    ST_START: begin
                        txd_q      <= shift_reg[0];
                        parity_acc <= upm_l[0] ^ shift_reg[0];
                        shift_reg  <= {1'b0, shift_reg[DATA_MAX-1:1]};
                        bit_cnt    <= 4'd1;
                        state      <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (bit_cnt < len_l) begin
                            txd_q      <= shift_reg[0];
                            parity_acc <= parity_acc ^ shift_reg[0];
                            shift_reg  <= {1'b0, shift_reg[DATA_MAX-1:1]};
                            bit_cnt    <= bit_cnt + 4'd1;
                        end else if (parity_en) begin
                            txd_q <= parity_acc;
                            state <= ST_PARITY;
                        end else begin
                            txd_q <= 1'b1;
                            state <= ST_STOP1;
                        end
                    end
                    ST_PARITY: begin
                        txd_q <= 1'b1;
                        state <= ST_STOP1;
                    end
                    ST_STOP1: begin
                        txd_q <= 1'b1;
                        state <= usbs_l ? ST_STOP2 : ST_IDLE;
                    end
                    ST_STOP2: begin
                        txd_q <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: begin
                        txd_q <= 1'b1;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Sticky transmit-complete flag; a frame-end set beats any clear
    always_ff @(posedge i_fosk) begin
        if (i_rst) begin
            txc_q <= 1'b0;
        end else if (txc_set) begin
            txc_q <= 1'b1;
        end else if (i_txc_clr || wr_accepted) begin
            txc_q <= 1'b0;
        end
    end

    // Drive outputs from the registered state
    always_comb begin
        o_TxD  = txd_q;
        o_txc  = txc_q;
        o_udre = !fifo_full;
        o_busy = (state != ST_IDLE);
    end

endmodule

// File: tb/tb_usart_tx_fifo_engine.sv
// Self-checking bench for usart_tx_fifo_engine (default build, no break).
// A queue-based model predicts the line, flags and FIFO level every cycle;
// directed frames are additionally checked against hand-computed bit strings.
module tb_usart_tx_fifo_engine;

    localparam int DATA_MAX   = 9;
    localparam int FIFO_DEPTH = 4;

    logic        i_fosk;
    logic        i_rst;
    logic        i_txclk;
    logic        i_txen;
    logic        i_we_udr;
    logic [8:0]  i_tx_data;
    logic [3:0]  i_char_len;
    logic [1:0]  i_upm;
    logic        i_usbs;
    logic        i_txc_clr;
    logic        o_TxD;
    logic        o_udre;
    logic        o_txc;
    logic        o_busy;
    logic [2:0]  o_level;

    int total = 0;
    int bad   = 0;

    logic [8:0] mq[$];
    bit         bq[$];
    bit         cap[$];
    bit         m_on   = 0;
    bit         m_txd  = 1;
    bit         m_txc  = 0;
    bit         m_busy = 0;

    usart_tx_fifo_engine #(
        .DATA_MAX   (DATA_MAX),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_fosk     (i_fosk),
        .i_rst      (i_rst),
        .i_txclk    (i_txclk),
        .i_txen     (i_txen),
        .i_we_udr   (i_we_udr),
        .i_tx_data  (i_tx_data),
        .i_char_len (i_char_len),
        .i_upm      (i_upm),
        .i_usbs     (i_usbs),
        .i_txc_clr  (i_txc_clr),
        .o_TxD      (o_TxD),
        .o_udre     (o_udre),
        .o_txc      (o_txc),
        .o_busy     (o_busy),
        .o_level    (o_level)
    );

    // System clock
    initial begin
        i_fosk = 0;
        forever #5 i_fosk = ~i_fosk;
    end

    // Baud pulse: one clock high out of every four
    initial begin
        int c;
        c = 0;
        i_txclk = 0;
        forever begin
            @(negedge i_fosk);
            c++;
            i_txclk = (c % 4 == 0);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [8:0] d);
        @(negedge i_fosk);
        i_we_udr  = 1;
        i_tx_data = d;
        @(negedge i_fosk);
        i_we_udr  = 0;
    endtask

    task automatic clearTxc();
        @(negedge i_fosk);
        i_txc_clr = 1;
        @(negedge i_fosk);
        i_txc_clr = 0;
    endtask

    task automatic waitTxc(input int bound);
        int n;
        n = 0;
        while (!o_txc && n < bound) begin
            @(negedge i_fosk);
            n++;
        end
        if (!o_txc) checkOutput("txc_timeout", o_txc, 1);
    endtask

    task automatic waitBusy(input int bound);
        int n;
        n = 0;
        while (!o_busy && n < bound) begin
            @(negedge i_fosk);
            n++;
        end
        if (!o_busy) checkOutput("busy_timeout", o_busy, 1);
    endtask

    task automatic waitTxclk(input int pulses);
        for (int p = 0; p < pulses; p++) begin
            do @(posedge i_fosk); while (!i_txclk);
        end
        @(negedge i_fosk);
    endtask

    // Compare n captured line bits, starting skip bits after the first 0, to exp
    task automatic checkFrame(input string name, input logic [15:0] exp, input int n, input int skip);
        int first;
        logic [15:0] act;
        first = -1;
        act = '0;
        for (int i = 0; i < cap.size(); i++) begin
            if (cap[i] == 1'b0) begin
                first = i;
                break;
            end
        end
        if (first >= 0) begin
            for (int k = 0; k < n; k++) begin
                if (first + skip + k < cap.size()) act[k] = cap[first + skip + k];
                else act[k] = 1'bx;
            end
        end
        checkOutput(name, 32'(act), 32'(exp));
    endtask

    // Reference model: a word queue for the FIFO and a bit queue for the line
    always @(posedge i_fosk) begin
        logic [8:0] word;
        int  len;
        int  ones;
        bit  wr_ok;
        bit  set_txc;
        bit  txclk_s;
        txclk_s = i_txclk;
        if (i_rst) begin
            m_on = 1;
            mq.delete();
            bq.delete();
            m_txd  = 1;
            m_txc  = 0;
            m_busy = 0;
        end else if (m_on) begin
            wr_ok   = i_we_udr && (mq.size() < FIFO_DEPTH);
            set_txc = 0;
            if (i_txclk) begin
                if (bq.size() == 0) begin
                    if (i_txen && mq.size() > 0) begin
                        word = mq.pop_front();
                        len  = int'(i_char_len);
                        if (len < 5) len = 5;
                        if (len > DATA_MAX) len = DATA_MAX;
                        ones = 0;
                        bq.push_back(1'b0);
                        for (int i = 0; i < len; i++) begin
                            bq.push_back(word[i]);
                            ones += int'(word[i]);
                        end
                        if (i_upm == 2'b10) bq.push_back((ones % 2) == 1);
                        if (i_upm == 2'b11) bq.push_back((ones % 2) == 0);
                        bq.push_back(1'b1);
                        if (i_usbs) bq.push_back(1'b1);
                        m_busy = 1;
                    end else begin
                        if (m_busy) set_txc = 1;
                        m_busy = 0;
                    end
                end
                if (bq.size() > 0) m_txd = bq.pop_front();
                else m_txd = 1;
            end
            if (wr_ok) mq.push_back(i_tx_data);
            if (set_txc) m_txc = 1;
            else if (i_txc_clr || wr_ok) m_txc = 0;
        end
        #1;
        if (m_on) begin
            checkOutput("cyc_txd",   o_TxD,   m_txd);
            checkOutput("cyc_txc",   o_txc,   m_txc);
            checkOutput("cyc_busy",  o_busy,  m_busy);
            checkOutput("cyc_udre",  o_udre,  mq.size() < FIFO_DEPTH);
            checkOutput("cyc_level", o_level, 32'(mq.size()));
            if (txclk_s) cap.push_back(o_TxD);
        end
    end

    initial begin
        i_rst = 1; i_txen = 0; i_we_udr = 0; i_tx_data = '0;
        i_char_len = 4'd8; i_upm = 2'b00; i_usbs = 0; i_txc_clr = 0;
        repeat (3) @(negedge i_fosk);
        checkOutput("rst_txd",   o_TxD,   1);
        checkOutput("rst_udre",  o_udre,  1);
        checkOutput("rst_txc",   o_txc,   0);
        checkOutput("rst_busy",  o_busy,  0);
        checkOutput("rst_level", o_level, 0);
        i_rst = 0;

        // T1: 8N1 'h55
        i_txen = 1; i_char_len = 4'd8; i_upm = 2'b00; i_usbs = 0;
        cap.delete();
        applyStimulus(9'h055);
        waitTxc(300);
        checkFrame("t1_8n1", 16'h02AA, 10, 0);
        checkOutput("t1_txc", o_txc, 1);
        clearTxc();

        // T2: 7E2 'h41
        i_char_len = 4'd7; i_upm = 2'b10; i_usbs = 1;
        cap.delete();
        applyStimulus(9'h041);
        waitTxc(300);
        checkFrame("t2_7e2", 16'h0682, 11, 0);
        clearTxc();

        // T3: 9O1 'h1FF
        i_char_len = 4'd9; i_upm = 2'b11; i_usbs = 0;
        cap.delete();
        applyStimulus(9'h1FF);
        waitTxc(300);
        checkFrame("t3_9o1", 16'h0BFE, 12, 0);
        clearTxc();

        // T4: fill the FIFO while disabled, fifth write dropped, then drain
        i_txen = 0; i_char_len = 4'd8; i_upm = 2'b00; i_usbs = 0;
        applyStimulus(9'h011);
        applyStimulus(9'h022);
        applyStimulus(9'h033);
        applyStimulus(9'h044);
        checkOutput("t4_udre_full", o_udre, 0);
        applyStimulus(9'h055);
        checkOutput("t4_level_full", o_level, 4);
        cap.delete();
        i_txen = 1;
        waitTxc(1000);
        checkFrame("t4_frame1", 16'h0222, 10, 0);
        checkFrame("t4_frame2_no_gap", 16'h0244, 10, 10);
        checkOutput("t4_level_empty", o_level, 0);
        clearTxc();

        // T5: reset in the middle of the data bits
        applyStimulus(9'h000);
        applyStimulus(9'h000);
        waitBusy(100);
        waitTxclk(4);
        i_rst = 1;
        @(posedge i_fosk);
        #2;
        checkOutput("t5_txd",   o_TxD,   1);
        checkOutput("t5_level", o_level, 0);
        checkOutput("t5_busy",  o_busy,  0);
        @(negedge i_fosk);
        i_rst = 0;
        cap.delete();
        applyStimulus(9'h0A5);
        waitTxc(300);
        checkFrame("t5_after_reset", 16'h034A, 10, 0);
        clearTxc();

        // T6: character length clamping at both ends
        i_char_len = 4'd2; i_upm = 2'b11; i_usbs = 1;
        cap.delete();
        applyStimulus(9'h1E3);
        waitTxc(300);
        checkFrame("t6_clamp_low", 16'h01C6, 9, 0);
        clearTxc();
        i_char_len = 4'd15; i_upm = 2'b10; i_usbs = 0;
        cap.delete();
        applyStimulus(9'h100);
        waitTxc(300);
        checkFrame("t6_clamp_high", 16'h0E00, 12, 0);
        clearTxc();

        // T7: dropping txen mid-frame finishes the frame and keeps the rest
        i_char_len = 4'd8; i_upm = 2'b00; i_usbs = 0;
        i_txen = 0;
        applyStimulus(9'h00F);
        applyStimulus(9'h0F0);
        i_txen = 1;
        waitBusy(100);
        @(negedge i_fosk);
        i_txen = 0;
        waitTxc(300);
        waitTxclk(3);
        checkOutput("t7_level_kept", o_level, 1);
        checkOutput("t7_idle", o_busy, 0);
        clearTxc();
        i_txen = 1;
        waitTxc(300);
        checkOutput("t7_drained", o_level, 0);
        waitTxclk(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
